// File: rtl/alu_pkg.sv
// Shared ALU types: operation encoding, flag bit positions and the request record
// presented by each requester of the shared ALU.
package alu_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        OR  = 2'b11
    } alu_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        alu_op_e     ctrl;
        logic        setflags;
    } alu_req_t;

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit ALU (ADD/SUB/AND/OR) producing {N,Z,C,V}.
// The clock input exists for interface compatibility and is not used.
module alu
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [1:0]  i_ctrl,
    output logic [31:0] o_result,
    output logic [3:0]  o_flags
);

    logic        w_unused_clk;
    logic [32:0] w_sum_ab;
    logic [31:0] w_diff;

    assign w_unused_clk = clk;
    assign w_sum_ab     = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff       = i_a - i_b;

    always_comb begin
        o_result = '0;
        case (alu_op_e'(i_ctrl))
            ADD:     o_result = w_sum_ab[31:0];
            SUB:     o_result = w_diff;
            AND:     o_result = i_a & i_b;
            default: o_result = i_a | i_b;
        endcase
    end

    // Carry is taken from the unmodified a+b sum for both ADD and SUB.
    assign o_flags[FLAG_N] = o_result[31];
    assign o_flags[FLAG_Z] = (o_result == 32'd0);
    assign o_flags[FLAG_C] = ~i_ctrl[1] & w_sum_ab[32];
    assign o_flags[FLAG_V] = ~i_ctrl[1] & (i_a[31] ^ o_result[31])
                           & ~(i_a[31] ^ i_ctrl[0] ^ i_b[31]);

endmodule

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set bit of i_valid searched from i_last+1
// upward (mod N), returned both as one-hot grant and as an index.
module rr_pick #(
    parameter int N   = 2,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   i_valid,
    input  logic [IDW-1:0] i_last,
    output logic [N-1:0]   o_grant,
    output logic [IDW-1:0] o_idx,
    output logic           o_any
);

    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        for (int k = 1; k <= N; k++) begin
            if (!o_any && i_valid[(int'(i_last) + k) % N]) begin
                o_any = 1'b1;
                o_idx = IDW'((int'(i_last) + k) % N);
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_grant
        assign o_grant[gi] = o_any && (o_idx == IDW'(gi));
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NREQ requesters with round-robin grant, a one-cycle
// registered response and the architectural NZCV register.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ*2-1:0]  req_ctrl,
    input  logic [NREQ-1:0]    req_setflags,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic [31:0]        rsp_result,
    output logic [3:0]         rsp_flags,
    output logic [3:0]         nzcv
);

    alu_req_t          w_reqs [NREQ];
    alu_req_t          w_sel;
    logic [NREQ-1:0]   w_valid_gated;
    logic [NREQ-1:0]   w_grant;
    logic [IDW-1:0]    w_idx;
    logic              w_any;
    logic [31:0]       w_result;
    logic [3:0]        w_flags;

    logic [IDW-1:0]    r_last;
    logic              r_rsp_valid;
    logic [IDW-1:0]    r_rsp_id;
    logic [31:0]       r_rsp_result;
    logic [3:0]        r_rsp_flags;
    logic [3:0]        r_nzcv;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign w_reqs[gi].a        = req_a[gi*32 +: 32];
        assign w_reqs[gi].b        = req_b[gi*32 +: 32];
        assign w_reqs[gi].ctrl     = alu_op_e'(req_ctrl[gi*2 +: 2]);
        assign w_reqs[gi].setflags = req_setflags[gi];
    end

    // Reset and stall both suppress grants before arbitration.
    assign w_valid_gated = (reset || stall) ? '0 : req_valid;

    rr_pick #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_pick (
        .i_valid (w_valid_gated),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign req_ready = w_grant;
    assign w_sel     = w_reqs[w_idx];

    alu u_alu (
        .clk      (clk),
        .i_a      (w_sel.a),
        .i_b      (w_sel.b),
        .i_ctrl   (w_sel.ctrl),
        .o_result (w_result),
        .o_flags  (w_flags)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last       <= IDW'(NREQ - 1);
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_nzcv       <= '0;
        end else if (w_any) begin
            r_last       <= w_idx;
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= w_idx;
            r_rsp_result <= w_result;
            r_rsp_flags  <= w_flags;
            if (w_sel.setflags) begin
                r_nzcv <= w_flags;
            end
        end else begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign nzcv       = r_nzcv;

endmodule
